// File: rtl/pci_blue_request_fifo_pkg.sv
// Shared constants and helpers for the host request FIFO feeding the PCI Master.
// Entry type encodings live here beside the other request-path constants.
package pci_blue_request_fifo_pkg;

    localparam logic [2:0] PCI_REQ_TYPE_RESERVED  = 3'b000;
    localparam logic [2:0] PCI_REQ_TYPE_ADDRESS   = 3'b001;
    localparam logic [2:0] PCI_REQ_TYPE_DATA      = 3'b010;
    localparam logic [2:0] PCI_REQ_TYPE_DATA_LAST = 3'b011;

    localparam int unsigned REQ_ENTRY_W = 39;

    localparam logic [0:0] SEQ_STATE_IDLE     = 1'b0;
    localparam logic [0:0] SEQ_STATE_IN_BURST = 1'b1;

    typedef struct packed {
        logic [2:0]  req_type;
        logic [3:0]  cbe;
        logic [31:0] data;
    } req_entry_t;

    // Whether an entry of this type may follow the current host stream state.
    function automatic logic seq_type_legal(input logic [2:0] req_type, input logic [0:0] seq_state);
        logic legal;
        case (req_type)
            PCI_REQ_TYPE_ADDRESS:   legal = (seq_state == SEQ_STATE_IDLE);
            PCI_REQ_TYPE_DATA:      legal = (seq_state == SEQ_STATE_IN_BURST);
            PCI_REQ_TYPE_DATA_LAST: legal = (seq_state == SEQ_STATE_IN_BURST);
            default:                legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Stream state after an accepted entry of this type.
    function automatic logic [0:0] seq_next_state(input logic [2:0] req_type, input logic [0:0] seq_state);
        logic [0:0] next_state;
        case (req_type)
            PCI_REQ_TYPE_ADDRESS:   next_state = SEQ_STATE_IN_BURST;
            PCI_REQ_TYPE_DATA_LAST: next_state = SEQ_STATE_IDLE;
            default:                next_state = seq_state;
        endcase
        return next_state;
    endfunction

endpackage

// File: rtl/pci_blue_request_fifo_storage.sv
// Register-array storage for the request FIFO: one write port, one asynchronous read port.
// Contents are deliberately not reset; occupancy tracking in the top decides what is valid.
module pci_blue_request_fifo_storage
    import pci_blue_request_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  pci_clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  req_entry_t            wr_entry,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output req_entry_t            rd_entry
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    req_entry_t mem_q [DEPTH];

    // Write the incoming entry into the addressed slot.
    always_ff @(posedge pci_clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_entry;
        end
    end

    assign rd_entry = mem_q[rd_addr];

endmodule

// File: rtl/pci_blue_request_fifo.sv
// Host Request FIFO ahead of the PCI Master: show-ahead head entry, sticky overflow error.
// Define PCI_BLUE_REQUEST_SEQUENCE_CHECK_EN to also reject mis-sequenced entry types.
module pci_blue_request_fifo
    import pci_blue_request_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic                  pci_clk,
    input  logic                  pci_reset_comb,
    input  logic [2:0]            host_request_type,
    input  logic [3:0]            host_request_cbe,
    input  logic [31:0]           host_request_data,
    input  logic                  host_request_load,
    output logic                  host_request_room_available,
    input  logic                  host_request_error_clear,
    output logic [2:0]            pci_iface_request_type,
    output logic [3:0]            pci_iface_request_cbe,
    output logic [31:0]           pci_iface_request_data,
    output logic                  pci_iface_request_data_available_meta,
    input  logic                  pci_iface_request_data_unload,
    output logic                  pci_iface_request_error,
    output logic [DEPTH_LOG2:0]   request_fifo_count
);

    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO   = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  available_q, available_d;
    logic                  room_q, room_d;
    logic                  error_q, error_d;
    logic                  seq_ok_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  error_set_s;
    req_entry_t            wr_entry_s;
    req_entry_t            rd_entry_s;

`ifdef PCI_BLUE_REQUEST_SEQUENCE_CHECK_EN
    logic [0:0] seq_state_q, seq_state_d;

    // Legality of the offered entry against the current host stream state.
    always_comb begin
        seq_ok_s = seq_type_legal(host_request_type, seq_state_q);
    end

    // Stream state only moves on entries actually stored.
    always_comb begin
        seq_state_d = seq_state_q;
        if (push_s) begin
            seq_state_d = seq_next_state(host_request_type, seq_state_q);
        end else begin
            seq_state_d = seq_state_q;
        end
    end

    // Stream state register.
    always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
        if (pci_reset_comb) begin
            seq_state_q <= SEQ_STATE_IDLE;
        end else begin
            seq_state_q <= seq_state_d;
        end
    end
`else
    // Without sequencing checks every type is stored as offered.
    always_comb begin
        seq_ok_s = 1'b1;
    end
`endif

    // Push/pop qualification, pointer and occupancy next-state, sticky error.
    always_comb begin
        push_s      = host_request_load & room_q & seq_ok_s;
        pop_s       = pci_iface_request_data_unload & available_q;
        // A full FIFO rejects the push even when a pop frees a slot this same cycle.
        error_set_s = host_request_load & ~(room_q & seq_ok_s);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        case ({push_s, pop_s})
            2'b10: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = count_q + CNT_ONE;
            end
            2'b01: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                count_d  = count_q - CNT_ONE;
            end
            2'b11: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            default: begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
            end
        endcase
        available_d = (count_d != CNT_ZERO);
        room_d      = (count_d != FULL_COUNT);
        if (error_set_s) begin
            error_d = 1'b1;
        end else if (host_request_error_clear) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
    end

    // Pointer, occupancy, flag and error registers.
    always_ff @(posedge pci_clk or posedge pci_reset_comb) begin
        if (pci_reset_comb) begin
            wr_ptr_q    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q    <= {DEPTH_LOG2{1'b0}};
            count_q     <= CNT_ZERO;
            available_q <= 1'b0;
            room_q      <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            available_q <= available_d;
            room_q      <= room_d;
            error_q     <= error_d;
        end
    end

    assign wr_entry_s = '{req_type: host_request_type, cbe: host_request_cbe, data: host_request_data};

    pci_blue_request_fifo_storage #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_storage (
        .pci_clk  (pci_clk),
        .wr_en    (push_s),
        .wr_addr  (wr_ptr_q),
        .wr_entry (wr_entry_s),
        .rd_addr  (rd_ptr_q),
        .rd_entry (rd_entry_s)
    );

    // Head entry is forced to zero while empty so stale storage never leaks out.
    always_comb begin
        if (available_q) begin
            pci_iface_request_type = rd_entry_s.req_type;
            pci_iface_request_cbe  = rd_entry_s.cbe;
            pci_iface_request_data = rd_entry_s.data;
        end else begin
            pci_iface_request_type = PCI_REQ_TYPE_RESERVED;
            pci_iface_request_cbe  = 4'h0;
            pci_iface_request_data = 32'h0000_0000;
        end
    end

    assign host_request_room_available           = room_q;
    assign pci_iface_request_data_available_meta = available_q;
    assign pci_iface_request_error               = error_q;
    assign request_fifo_count                    = count_q;

endmodule

// File: tb/tb_pci_blue_request_fifo.sv
// Scoreboard bench for the host request FIFO: a queue-based reference model plus directed
// and randomized traffic; honours PCI_BLUE_REQUEST_SEQUENCE_CHECK_EN when defined.
module tb_pci_blue_request_fifo;
    import pci_blue_request_fifo_pkg::*;

    localparam int DEPTH = 8;

    logic        pci_clk = 1'b0;
    logic        pci_reset_comb = 1'b1;
    logic [2:0]  host_request_type = 3'b000;
    logic [3:0]  host_request_cbe = 4'h0;
    logic [31:0] host_request_data = 32'h0;
    logic        host_request_load = 1'b0;
    logic        host_request_room_available;
    logic        host_request_error_clear = 1'b0;
    logic [2:0]  pci_iface_request_type;
    logic [3:0]  pci_iface_request_cbe;
    logic [31:0] pci_iface_request_data;
    logic        pci_iface_request_data_available_meta;
    logic        pci_iface_request_data_unload = 1'b0;
    logic        pci_iface_request_error;
    logic [3:0]  request_fifo_count;

    pci_blue_request_fifo dut (
        .pci_clk                               (pci_clk),
        .pci_reset_comb                        (pci_reset_comb),
        .host_request_type                     (host_request_type),
        .host_request_cbe                      (host_request_cbe),
        .host_request_data                     (host_request_data),
        .host_request_load                     (host_request_load),
        .host_request_room_available           (host_request_room_available),
        .host_request_error_clear              (host_request_error_clear),
        .pci_iface_request_type                (pci_iface_request_type),
        .pci_iface_request_cbe                 (pci_iface_request_cbe),
        .pci_iface_request_data                (pci_iface_request_data),
        .pci_iface_request_data_available_meta (pci_iface_request_data_available_meta),
        .pci_iface_request_data_unload         (pci_iface_request_data_unload),
        .pci_iface_request_error               (pci_iface_request_error),
        .request_fifo_count                    (request_fifo_count)
    );

    always #5 pci_clk = ~pci_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [38:0] exp_q[$];
    int          exp_count = 0;
    logic        exp_err = 1'b0;
    logic        exp_in_burst = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: a bounded queue updated at each clock edge from the inputs.
    initial begin : model
        logic legal, accept, pop;
        forever begin
            @(posedge pci_clk);
            if (pci_reset_comb) begin
                exp_q.delete();
                exp_count    = 0;
                exp_err      = 1'b0;
                exp_in_burst = 1'b0;
            end else begin
                legal = 1'b1;
`ifdef PCI_BLUE_REQUEST_SEQUENCE_CHECK_EN
                if (host_request_type == 3'b001)      legal = !exp_in_burst;
                else if (host_request_type == 3'b010) legal = exp_in_burst;
                else if (host_request_type == 3'b011) legal = exp_in_burst;
                else                                  legal = 1'b0;
`endif
                accept = host_request_load && (exp_count < DEPTH) && legal;
                pop    = pci_iface_request_data_unload && (exp_count > 0);
                if (host_request_load && !accept) exp_err = 1'b1;
                else if (host_request_error_clear) exp_err = 1'b0;
                if (accept) begin
                    exp_q.push_back({host_request_type, host_request_cbe, host_request_data});
                    if (host_request_type == 3'b001) exp_in_burst = 1'b1;
                    if (host_request_type == 3'b011) exp_in_burst = 1'b0;
                end
                exp_count = exp_count + (accept ? 1 : 0) - (pop ? 1 : 0);
            end
        end
    end

    // Monitor: compare outputs mid-cycle; retire the head entry when the Master takes it.
    initial begin : monitor
        forever begin
            @(negedge pci_clk);
            if (!pci_reset_comb) begin
                check("count", 64'(request_fifo_count), 64'(exp_count));
                check("available", 64'(pci_iface_request_data_available_meta), 64'(exp_count != 0));
                check("room", 64'(host_request_room_available), 64'(exp_count != DEPTH));
                check("error", 64'(pci_iface_request_error), 64'(exp_err));
                if (exp_count == 0) begin
                    check("head_empty", 64'({pci_iface_request_type, pci_iface_request_cbe,
                                             pci_iface_request_data}), 64'h0);
                end else if (exp_q.size() == 0) begin
                    check("scoreboard_sync", 64'(exp_q.size()), 64'(exp_count));
                end else begin
                    check("head", 64'({pci_iface_request_type, pci_iface_request_cbe,
                                       pci_iface_request_data}), 64'(exp_q[0]));
                    if (pci_iface_request_data_unload) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic ld, input logic [2:0] t, input logic [3:0] c,
                         input logic [31:0] d, input logic ul, input logic clr);
        host_request_load             = ld;
        host_request_type             = t;
        host_request_cbe              = c;
        host_request_data             = d;
        pci_iface_request_data_unload = ul;
        host_request_error_clear      = clr;
        @(posedge pci_clk);
        #2;
        host_request_load             = 1'b0;
        pci_iface_request_data_unload = 1'b0;
        host_request_error_clear      = 1'b0;
    endtask

    task automatic push(input logic [2:0] t, input logic [3:0] c, input logic [31:0] d);
        drive(1'b1, t, c, d, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        drive(1'b0, 3'b000, 4'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        pci_reset_comb = 1'b1;
        repeat (2) @(posedge pci_clk);
        #2;
        pci_reset_comb = 1'b0;
    endtask

    // Eight entries forming one legal burst.
    task automatic push_burst8(input logic [31:0] base);
        push(PCI_REQ_TYPE_ADDRESS, 4'h7, base);
        for (int i = 1; i < 7; i++) push(PCI_REQ_TYPE_DATA, 4'(i), base + 32'(i));
        push(PCI_REQ_TYPE_DATA_LAST, 4'hF, base + 32'd7);
    endtask

    initial begin : stimulus
        logic [2:0] rt;
        #1;
        do_reset();
        drive(1'b0, 3'b000, 4'h0, 32'h0, 1'b0, 1'b0);

        // Reset state
        check("rst_available", 64'(pci_iface_request_data_available_meta), 64'h0);
        check("rst_room", 64'(host_request_room_available), 64'h1);
        check("rst_count", 64'(request_fifo_count), 64'h0);
        check("rst_head", 64'({pci_iface_request_type, pci_iface_request_cbe, pci_iface_request_data}), 64'h0);
        check("rst_error", 64'(pci_iface_request_error), 64'h0);

        // Two-entry transfer
        push(PCI_REQ_TYPE_ADDRESS, 4'h7, 32'h1000_0000);
        push(PCI_REQ_TYPE_DATA_LAST, 4'h0, 32'hDEAD_BEEF);
        check("two_count", 64'(request_fifo_count), 64'h2);
        check("two_head1", 64'({pci_iface_request_type, pci_iface_request_cbe, pci_iface_request_data}),
              64'h1_7_1000_0000 >> 0);
        pop_one();
        check("two_head2", 64'(pci_iface_request_data), 64'hDEAD_BEEF);
        pop_one();
        check("two_drained", 64'(pci_iface_request_data_available_meta), 64'h0);
        check("two_count0", 64'(request_fifo_count), 64'h0);

        // Fill, then overflow
        push_burst8(32'hA000_0000);
        check("full_room", 64'(host_request_room_available), 64'h0);
        check("full_count", 64'(request_fifo_count), 64'h8);
        push(PCI_REQ_TYPE_ADDRESS, 4'h1, 32'hBAD0_0000);
        check("ovf_error", 64'(pci_iface_request_error), 64'h1);
        check("ovf_count", 64'(request_fifo_count), 64'h8);
        repeat (8) pop_one();

        // Error clear alone, then clear coincident with overflow
        drive(1'b0, 3'b000, 4'h0, 32'h0, 1'b0, 1'b1);
        check("clr_error", 64'(pci_iface_request_error), 64'h0);
        push_burst8(32'hB000_0000);
        drive(1'b1, PCI_REQ_TYPE_ADDRESS, 4'h2, 32'hBAD1_0000, 1'b1, 1'b1);
        check("clr_vs_set", 64'(pci_iface_request_error), 64'h1);
        check("full_pop_count", 64'(request_fifo_count), 64'h7);
        repeat (7) pop_one();
        drive(1'b0, 3'b000, 4'h0, 32'h0, 1'b0, 1'b1);

        // Steady state at count 4 with simultaneous push and pop
        push(PCI_REQ_TYPE_ADDRESS, 4'h3, 32'hC000_0000);
        for (int i = 1; i < 4; i++) push(PCI_REQ_TYPE_DATA, 4'h3, 32'hC000_0000 + 32'(i));
        for (int i = 0; i < 20; i++)
            drive(1'b1, PCI_REQ_TYPE_DATA, 4'(i), 32'hC100_0000 + 32'(i), 1'b1, 1'b0);
        check("steady_count", 64'(request_fifo_count), 64'h4);
        repeat (4) pop_one();

        // Sequencing
        do_reset();
        push(PCI_REQ_TYPE_DATA, 4'h1, 32'h0000_0001);
        push(PCI_REQ_TYPE_ADDRESS, 4'h2, 32'h0000_0002);
        push(PCI_REQ_TYPE_ADDRESS, 4'h3, 32'h0000_0003);
        push(PCI_REQ_TYPE_DATA, 4'h4, 32'h0000_0004);
        push(PCI_REQ_TYPE_DATA_LAST, 4'h5, 32'h0000_0005);
`ifdef PCI_BLUE_REQUEST_SEQUENCE_CHECK_EN
        check("seq_count", 64'(request_fifo_count), 64'h3);
        check("seq_error", 64'(pci_iface_request_error), 64'h1);
`else
        check("seq_count", 64'(request_fifo_count), 64'h5);
        check("seq_error", 64'(pci_iface_request_error), 64'h0);
`endif
        repeat (5) pop_one();

        // Randomized traffic with occasional resets and clears
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                rt = 3'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) rt = 3'($urandom_range(4, 7));
                drive(1'($urandom_range(0, 1)), rt, 4'($urandom_range(0, 15)), 32'($urandom),
                      1'($urandom_range(0, 2) != 0 ? (i % 64 < 32 ? 1 : $urandom_range(0, 1)) : 0),
                      1'($urandom_range(0, 19) == 0));
            end
        end
        repeat (2) @(posedge pci_clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
